// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle RV32I load/store unit driving a word-wide
//            request/acknowledge data-memory bus. Word-crossing accesses are
//            split into two bus transactions; loads are sign/zero extended.
// Ports    : clock, reset (sync, active-low)
//            start, mem_read, mem_write, funct3, address, store_data  - request
//            busy, done, error, load_data                             - status
//            bus_req, bus_we, bus_addr, bus_be, bus_wdata             - bus out
//            bus_rdata, bus_ack                                       - bus in
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ1 = 2'd1;
    localparam logic [1:0] c_REQ2 = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic        r_split;
    logic        r_is_store;
    logic [3:0]  r_be_hi;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_rdata1;

    logic [1:0]  w_state_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_error_nxt;
    logic [31:0] w_load_data_nxt;
    logic        w_bus_req_nxt;
    logic        w_bus_we_nxt;
    logic [31:0] w_bus_addr_nxt;
    logic [3:0]  w_bus_be_nxt;
    logic [31:0] w_bus_wdata_nxt;
    logic        w_capture;

    logic [3:0]  w_mask;
    logic [7:0]  w_be_wide;
    logic [63:0] w_wdata_wide;
    logic        w_size_ok;
    logic        w_legal;
    logic [63:0] w_pair;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    // Byte-enable mask and write data are formed as a double-word window:
    // the low half feeds the first transaction, the high half the second.
    assign w_mask       = (funct3[1:0] == 2'b00) ? 4'b0001 :
                          (funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign w_be_wide    = {4'b0000, w_mask} << address[1:0];
    assign w_wdata_wide = {32'h0, store_data} << {address[1:0], 3'b000};

    assign w_size_ok = (funct3[1:0] != 2'b11);
    // Stores allow B/H/W only; loads additionally allow BU/HU.
    assign w_legal   = mem_write ? (w_size_ok && !funct3[2])
                                 : (w_size_ok && !(funct3[2] && funct3[1]));

    // Upper word is zero unless the second half of a split load is arriving.
    assign w_pair = (r_state == c_REQ2) ? {bus_rdata, r_rdata1} : {32'h0, bus_rdata};
    assign w_raw  = w_pair[{r_offset, 3'b000} +: 32];
    assign w_ext  = extend_load(r_funct3, w_raw);

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = busy;
        w_done_nxt      = 1'b0;
        w_error_nxt     = 1'b0;
        w_load_data_nxt = load_data;
        w_bus_req_nxt   = bus_req;
        w_bus_we_nxt    = bus_we;
        w_bus_addr_nxt  = bus_addr;
        w_bus_be_nxt    = bus_be;
        w_bus_wdata_nxt = bus_wdata;
        w_capture       = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    if (!w_legal) begin
                        w_done_nxt  = 1'b1;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_capture       = 1'b1;
                        w_state_nxt     = c_REQ1;
                        w_busy_nxt      = 1'b1;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = mem_write;
                        w_bus_addr_nxt  = {address[31:2], 2'b00};
                        w_bus_be_nxt    = w_be_wide[3:0];
                        w_bus_wdata_nxt = w_wdata_wide[31:0];
                    end
                end
            end
            c_REQ1: begin
                if (bus_ack) begin
                    if (r_split) begin
                        w_state_nxt     = c_REQ2;
                        w_bus_addr_nxt  = bus_addr + 32'd4;
                        w_bus_be_nxt    = r_be_hi;
                        w_bus_wdata_nxt = r_wdata_hi;
                    end else begin
                        w_state_nxt   = c_IDLE;
                        w_busy_nxt    = 1'b0;
                        w_bus_req_nxt = 1'b0;
                        w_bus_we_nxt  = 1'b0;
                        w_done_nxt    = 1'b1;
                        if (!r_is_store) begin
                            w_load_data_nxt = w_ext;
                        end
                    end
                end
            end
            c_REQ2: begin
                if (bus_ack) begin
                    w_state_nxt   = c_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_bus_req_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                    if (!r_is_store) begin
                        w_load_data_nxt = w_ext;
                    end
                end
            end
            default: begin
                w_state_nxt   = c_IDLE;
                w_busy_nxt    = 1'b0;
                w_bus_req_nxt = 1'b0;
                w_bus_we_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            load_data  <= 32'h0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_be     <= 4'h0;
            bus_wdata  <= 32'h0;
            r_funct3   <= 3'b000;
            r_offset   <= 2'b00;
            r_split    <= 1'b0;
            r_is_store <= 1'b0;
            r_be_hi    <= 4'h0;
            r_wdata_hi <= 32'h0;
            r_rdata1   <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            error     <= w_error_nxt;
            load_data <= w_load_data_nxt;
            bus_req   <= w_bus_req_nxt;
            bus_we    <= w_bus_we_nxt;
            bus_addr  <= w_bus_addr_nxt;
            bus_be    <= w_bus_be_nxt;
            bus_wdata <= w_bus_wdata_nxt;
            if (w_capture) begin
                r_funct3   <= funct3;
                r_offset   <= address[1:0];
                r_split    <= |w_be_wide[7:4];
                r_is_store <= mem_write;
                r_be_hi    <= w_be_wide[7:4];
                r_wdata_hi <= w_wdata_wide[63:32];
            end
            if ((r_state == c_REQ1) && bus_ack) begin
                r_rdata1 <= bus_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. A byte-addressed memory
//            model predicts bus transactions and load results; a bus responder
//            acks with random latency; a monitor pops expectations and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    load_store_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .load_data  (load_data),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_txn_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
    } resp_t;

    bus_txn_t    bus_q[$];
    resp_t       resp_q[$];
    int          start_q[$];
    logic [31:0] mem [logic [31:0]];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          force_delay = -1;
    logic        mon_en  = 1'b0;
    logic [31:0] model_ld = 32'h0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = get_word({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // Issue one request once the unit is idle; pushes the expected bus
    // transactions and completion into the scoreboard queues.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input int lat);
        int          guard;
        int          n;
        logic        st;
        logic        legal;
        logic        two;
        logic [31:0] wa;
        logic [31:0] last;
        logic [31:0] idx;
        logic [31:0] ld;
        bus_txn_t    t;
        resp_t       r;
        guard = 0;
        while (busy === 1'b1 && guard < 300) begin
            start      = ($urandom_range(0, 3) == 0);
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            funct3     = 3'($urandom);
            address    = $urandom;
            store_data = $urandom;
            @(negedge clock);
            guard++;
        end
        if (guard >= 300) check("idle_timeout", {31'h0, busy}, 32'h0);
        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        address = a; store_data = sd;
        if (rd || wr) begin
            st    = wr;
            legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                       : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            if (legal) begin
                n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                wa   = {a[31:2], 2'b00};
                last = a + n - 1;
                two  = ({last[31:2], 2'b00} != wa);
                for (int k = 0; k < (two ? 2 : 1); k++) begin
                    t.addr = wa + 4 * k;
                    t.we = st; t.be = 4'h0; t.wdata = 32'h0;
                    for (int L = 0; L < 4; L++) begin
                        idx = t.addr + L - a;
                        if (idx < n) t.be[L] = 1'b1;
                        if (idx < 4) t.wdata[8*L +: 8] = sd[{idx[1:0], 3'b000} +: 8];
                    end
                    bus_q.push_back(t);
                end
                if (!st) begin
                    ld = 32'h0;
                    for (int i = 0; i < n; i++) ld[8*i +: 8] = mem_byte(a + i);
                    case (f3)
                        3'b000:  ld = {{24{ld[7]}}, ld[7:0]};
                        3'b001:  ld = {{16{ld[15]}}, ld[15:0]};
                        default: ;
                    endcase
                    model_ld = ld;
                end
            end
            r.err = !legal; r.data = model_ld; r.lat = lat;
            resp_q.push_back(r);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    // Bus responder: word memory with random (or forced) ack latency and
    // occasional stray acks while no request is pending.
    initial begin
        logic active;
        int   cnt;
        bus_ack = 1'b0; bus_rdata = 32'h0; active = 1'b0; cnt = 0;
        forever begin
            @(negedge clock);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (reset === 1'b1 && bus_req === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    bus_ack = 1'b1;
                    if (!bus_we) bus_rdata = get_word(bus_addr);
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                active = 1'b0;
                if ($urandom_range(0, 7) == 0) bus_ack = 1'b1;
            end
        end
    end

    // Monitor: compares bus transactions, request stability and completions.
    initial begin
        logic     prev_req;
        logic     prev_acked;
        bus_txn_t held;
        bus_txn_t e;
        resp_t    r;
        int       s;
        int       last_ack;
        prev_req = 1'b0; prev_acked = 1'b0; last_ack = -100;
        forever begin
            @(negedge clock);
            #1;
            if (mon_en) begin
                if (start && (mem_read || mem_write) && !busy && reset) start_q.push_back(cyc);
                if (bus_req) begin
                    if (!prev_req || prev_acked) begin
                        if (bus_q.size() == 0) begin
                            check("bus_req_unexpected", {31'h0, bus_req}, 32'h0);
                        end else begin
                            e = bus_q.pop_front();
                            check("bus_addr", bus_addr, e.addr);
                            check("bus_be", {28'h0, bus_be}, {28'h0, e.be});
                            check("bus_we", {31'h0, bus_we}, {31'h0, e.we});
                            check("bus_wdata", bus_wdata, e.wdata);
                        end
                        held.addr = bus_addr; held.be = bus_be;
                        held.we = bus_we; held.wdata = bus_wdata;
                    end else begin
                        check("hold_addr", bus_addr, held.addr);
                        check("hold_be", {28'h0, bus_be}, {28'h0, held.be});
                        check("hold_we", {31'h0, bus_we}, {31'h0, held.we});
                        check("hold_wdata", bus_wdata, held.wdata);
                    end
                end
                if (bus_req && bus_ack) last_ack = cyc;
                if (error && !done) check("error_without_done", {31'h0, error}, 32'h0);
                if (done) begin
                    if (resp_q.size() == 0) begin
                        check("done_unexpected", {31'h0, done}, 32'h0);
                    end else begin
                        r = resp_q.pop_front();
                        check("error", {31'h0, error}, {31'h0, r.err});
                        check("load_data", load_data, r.data);
                        check("busy_at_done", {31'h0, busy}, 32'h0);
                        check("bus_req_at_done", {31'h0, bus_req}, 32'h0);
                        if (start_q.size() != 0) begin
                            s = start_q.pop_front();
                            if (r.lat >= 0) check("latency", cyc - s, r.lat);
                            if (r.err) check("error_latency", cyc - s, 1);
                            else       check("done_after_ack", cyc - last_ack, 1);
                        end else begin
                            check("start_not_seen", {31'h0, done}, 32'h0);
                        end
                    end
                end
                prev_req   = bus_req;
                prev_acked = bus_req && bus_ack;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int       g;
        logic     rd;
        logic     wr;
        logic [31:0] a;
        reset = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; address = 32'h0; store_data = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        reset  = 1'b1;
        mon_en = 1'b1;

        mem[32'h0000_0100] = 32'hDEADBEEF;
        mem[32'h0000_0000] = 32'h80FFFFFF;
        mem[32'h0000_0004] = 32'h000000FF;

        force_delay = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 2);          // LW
        force_delay = 3;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 5);  // SB
        force_delay = 0;
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 3);          // LH split
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'h0, 3);          // LHU split
        issue(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 3);  // SW wrap
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0, 1);          // illegal
        issue(1'b1, 1'b1, 3'b100, 32'h0000_0020, 32'h0, 1);          // illegal store

        // Start while busy must be ignored.
        force_delay = 6;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, -1);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; address = 32'h0000_0500;
        @(negedge clock);
        start = 1'b0;
        check("busy_start_addr", bus_addr, 32'h0000_0300);
        @(negedge clock);
        check("busy_start_addr2", bus_addr, 32'h0000_0300);

        // Reset in the middle of a request aborts it without done.
        force_delay = 20;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0041, 32'h0, -1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        resp_q.delete(); start_q.delete(); bus_q.delete();
        model_ld = 32'h0;
        check("abort_bus_req", {31'h0, bus_req}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_load_data", load_data, 32'h0);
        force_delay = -1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 300; i++) begin
            force_delay = -1;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            g  = int'($urandom_range(0, 7));
            rd = (g != 0) && ($urandom_range(0, 1) == 1);
            wr = (g != 0) && (!rd || ($urandom_range(0, 3) == 0));
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = {22'h0, 10'($urandom)};
                2:       a = 32'hFFFF_FFFC + $urandom_range(0, 3);
                default: a = {$urandom_range(0, 15), 2'b00} + $urandom_range(0, 3);
            endcase
            issue(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, -1);
        end

        g = 0;
        while ((resp_q.size() != 0 || busy === 1'b1) && g < 500) begin
            @(negedge clock);
            g++;
        end
        repeat (3) @(negedge clock);
        check("drain_resp_q", resp_q.size(), 32'h0);
        check("drain_bus_q", bus_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that sits directly downstream of the ALU. It takes the ALU result as the effective address for RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW). It drives a word-wide request/acknowledge data-memory bus. Misaligned accesses that cross a word boundary are split into two bus transactions, and loaded data is returned sign- or zero-extended.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- start  in  1  one-cycle request pulse; accepted only while idle
- mem_read  in  1  load request (qualifies start)
- mem_write  in  1  store request (qualifies start); wins if both high
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  in  32  effective byte address (ALU_result)
- store_data  in  32  store source (rs2), LSBs used for B/H
- busy  out  1  high while a request is in flight (core stall)
- done  out  1  one-cycle completion pulse
- error  out  1  pulses with done on illegal request
- load_data  out  32  extended load result, held until next accepted load
- bus_req  out  1  bus request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address (bits[1:0] = 0)
- bus_be  out  4  byte enables, bit i = byte lane i
- bus_wdata  out  32  lane-aligned write data
- bus_rdata  in  32  read data, valid in the ack cycle
- bus_ack  in  1  transaction complete this cycle

## Operation
- FSM states:
  - IDLE: on start with mem_read or mem_write, capture funct3, address and store_data, then go to REQ1. Start with both low is ignored.
  - REQ1: hold the first transaction until bus_ack. Then go to REQ2 if the access is split; otherwise go to IDLE with done=1.
  - REQ2: hold the second transaction until bus_ack, then go to IDLE with done=1.
- Size n = 1/2/4 bytes from funct3[1:0]. Offset o = address[1:0]. The access is split iff o+n > 4.
- Legal funct3 for loads: 000, 001, 010, 100, 101. Legal for stores: 000, 001, 010.
- Illegal request: go to IDLE with done=1 and error=1 one cycle after start. No bus activity. load_data is unchanged.
- First transaction:
  - bus_addr = {address[31:2], 2'b00}
  - bus_be = (2^n − 1) << o, truncated to 4 bits
  - bus_wdata = store_data << 8·o
- Second transaction:
  - bus_addr = first address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000)
  - bus_be = (2^n − 1) >> (4 − o)
  - bus_wdata = store_data >> 8·(4 − o)
- Load data path:
  - Capture bus_rdata at each ack into r1 and r2.
  - raw = ({r2, r1} >> 8·o)[31:0]; r2 is treated as 0 when the access is not split.
  - Extension: B sign-extends raw[7:0], BU zero-extends raw[7:0], H sign-extends raw[15:0], HU zero-extends raw[15:0], W passes raw through.
  - load_data updates in the done cycle.
- Stores: bus_we=1 for both halves. load_data is unchanged.
- Inputs are ignored while not in IDLE, including start while busy. There is no queueing.
- bus_ack while bus_req=0 is ignored.

## Timing
- Reset (reset=0 at an edge): next cycle state=IDLE and busy, done, error, bus_req, bus_we = 0. bus_addr, bus_be, bus_wdata and load_data = 0.
- Reset mid-transaction aborts it. bus_req drops the next cycle and no done is issued.
- All outputs are registered.
- Start sampled at edge k:
  - busy=1 and bus_req=1 from cycle k+1.
  - Ack at the first request cycle: non-split done at cycle k+2; split done at cycle k+3.
  - Each cycle without ack adds one cycle of latency.
- Request stability: bus_req, bus_addr, bus_we, bus_be and bus_wdata are stable from the first request cycle through the ack cycle inclusive.
- Between halves: bus_req stays high and the second-half values appear the cycle after the first ack.
- Completion cycle: busy=0 and bus_req=0 when done=1.
- Back-to-back: start in the done cycle is accepted, giving bus_req=1 again the following cycle.
- done and error are single-cycle pulses.

## Test plan
- LW at 0x00000100, bus_rdata=0xDEADBEEF with ack in the first request cycle:
  - one request: bus_addr=0x100, be=1111
  - done 2 cycles after start, load_data=0xDEADBEEF
- SB at 0x00000203 with store_data=0x000000A5:
  - bus_addr=0x200, be=1000, wdata=0xA5000000, we=1
  - ack delayed 3 cycles: outputs stable throughout, done 5 cycles after start
- LH at 0x00000003, word 0 rdata=0x80FFFFFF, word 1 rdata=0x000000FF:
  - two requests: addr 0x0 be=1000, then addr 0x4 be=0001
  - load_data=0xFFFFFF80; same access as LHU gives 0x0000FF80
- SW at 0xFFFFFFFE with store_data=0x11223344:
  - addr 0xFFFFFFFC be=1100 wdata=0x33440000
  - then addr 0x00000000 be=0011 wdata=0x00001122
- Start with funct3=011 and mem_read=1:
  - no bus_req; done=1 and error=1 one cycle after start
  - load_data unchanged
- Reset and start handling:
  - reset=0 while in REQ1 with no ack: next cycle bus_req=0, busy=0, no done
  - start while busy is ignored: bus_addr unchanged
